// File: rtl/multicycle_ctrl.sv
// Main control FSM of a multicycle MIPS datapath.
// The opcode is decoded one state at a time. Every datapath mux select and
// architectural write enable is decoded combinationally from the current
// state, plus opcode/zero/mem_ready where a state needs them.
// While rst_n is low, every output is forced to 0, including the debug state.
module multicycle_ctrl #(
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter bit JAL_EN      = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       i_or_d,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_JAL       = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // The state register is kept as a plain vector, so that codes 13-15 can be
    // represented and recovered from.
    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       mem_rdy;
    logic       jal_ok;

    assign mem_rdy = MEM_WAIT_EN ? mem_ready : 1'b1;
    assign jal_ok  = JAL_EN && (opcode == OP_JAL);

    // Next-state selection; unused codes fall back to FETCH.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:     state_d = mem_rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (opcode == OP_RTYPE)                        state_d = S_R_EXEC;
                else if (opcode == OP_LW || opcode == OP_SW)   state_d = S_MEM_ADDR;
                else if (opcode == OP_BEQ)                     state_d = S_BRANCH;
                else if (opcode == OP_ADDI)                    state_d = S_ADDI_EXEC;
                else if (opcode == OP_J)                       state_d = S_JUMP;
                else if (jal_ok)                               state_d = S_JAL;
                else                                           state_d = S_FETCH;
            end
            S_MEM_ADDR:  state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  state_d = mem_rdy ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: state_d = mem_rdy ? S_FETCH : S_MEM_WRITE;
            S_R_EXEC:    state_d = S_R_WB;
            S_R_WB:      state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_ADDI_WB:   state_d = S_FETCH;
            S_JAL:       state_d = S_FETCH;
            default:     state_d = S_FETCH;
        endcase
    end

    // State register with asynchronous reset to FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Output decode; everything is held at 0 while reset is asserted.
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        i_or_d     = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        alu_op     = 2'd0;
        pc_src     = 2'd0;
        reg_dst    = 2'd0;
        mem_to_reg = 2'd0;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        state      = 4'd0;
        if (rst_n) begin
            state = state_q;
            case (state_q)
                S_FETCH: begin
                    alu_src_b = 2'd1;
                    ir_write  = mem_rdy;
                    pc_write  = mem_rdy;
                end
                S_DECODE: begin
                    alu_src_b = 2'd3;
                    if (!(opcode == OP_RTYPE || opcode == OP_LW || opcode == OP_SW ||
                          opcode == OP_BEQ || opcode == OP_ADDI || opcode == OP_J || jal_ok))
                        illegal_op = 1'b1;
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd2;
                end
                S_MEM_READ: i_or_d = 1'b1;
                S_MEM_WB: begin
                    mem_to_reg = 2'd1;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                // mem_write stays high through wait cycles; memory takes it on the ready cycle.
                S_MEM_WRITE: begin
                    i_or_d     = 1'b1;
                    mem_write  = 1'b1;
                    instr_done = mem_rdy;
                end
                S_R_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'd2;
                end
                S_R_WB: begin
                    reg_dst    = 2'd1;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a  = 1'b1;
                    alu_op     = 2'd1;
                    pc_src     = 2'd1;
                    pc_write   = zero;
                    instr_done = 1'b1;
                end
                S_JUMP: begin
                    pc_src     = 2'd2;
                    pc_write   = 1'b1;
                    instr_done = 1'b1;
                end
                S_ADDI_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd2;
                end
                S_ADDI_WB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                // PC already holds PC+4 from FETCH, so it is the link value.
                S_JAL: begin
                    reg_dst    = 2'd2;
                    mem_to_reg = 2'd2;
                    reg_write  = 1'b1;
                    pc_src     = 2'd2;
                    pc_write   = 1'b1;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: instruction-level reference model with random wait states.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, ir_write, mem_write, reg_write, i_or_d, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_src, reg_dst, mem_to_reg;
    logic       instr_done, illegal_op;
    logic [3:0] state;

    logic [5:0] d2_opcode;
    logic       d2_zero, d2_mem_ready;
    logic       d2_pc_write, d2_ir_write, d2_mem_write, d2_reg_write, d2_i_or_d, d2_alu_src_a;
    logic [1:0] d2_alu_src_b, d2_alu_op, d2_pc_src, d2_reg_dst, d2_mem_to_reg;
    logic       d2_instr_done, d2_illegal_op;
    logic [3:0] d2_state;

    int errors = 0;
    int checks = 0;

    logic [21:0] all_out;
    assign all_out = {pc_write, ir_write, mem_write, reg_write, i_or_d, alu_src_a, alu_src_b,
                      alu_op, pc_src, reg_dst, mem_to_reg, instr_done, illegal_op, state};

    // Clock
    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .mem_write(mem_write), .reg_write(reg_write),
        .i_or_d(i_or_d), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_src(pc_src), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
    );

    multicycle_ctrl #(.MEM_WAIT_EN(1'b0), .JAL_EN(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .opcode(d2_opcode), .zero(d2_zero), .mem_ready(d2_mem_ready),
        .pc_write(d2_pc_write), .ir_write(d2_ir_write), .mem_write(d2_mem_write),
        .reg_write(d2_reg_write), .i_or_d(d2_i_or_d), .alu_src_a(d2_alu_src_a),
        .alu_src_b(d2_alu_src_b), .alu_op(d2_alu_op), .pc_src(d2_pc_src),
        .reg_dst(d2_reg_dst), .mem_to_reg(d2_mem_to_reg),
        .instr_done(d2_instr_done), .illegal_op(d2_illegal_op), .state(d2_state)
    );

    function automatic logic is_legal(input logic [5:0] op);
        return op == 6'h00 || op == 6'h02 || op == 6'h03 || op == 6'h04 ||
               op == 6'h08 || op == 6'h23 || op == 6'h2B;
    endfunction

    // Runs one instruction from the start of FETCH: fw fetch wait cycles, mw memory wait cycles.
    task automatic run_instr(input logic [5:0] op, input logic z, input int fw, input int mw);
        logic [3:0] exp_q[$];
        logic [3:0] exp_s;
        logic is_lw, is_sw, is_mem, legal;
        int lat, base;
        int n_rw, n_mw, n_pcw, n_irw, n_done, n_ill;
        int exp_rw, exp_pcw;
        logic [1:0] exp_dst, exp_m2r;

        is_lw  = (op == 6'h23);
        is_sw  = (op == 6'h2B);
        is_mem = is_lw || is_sw;
        legal  = is_legal(op);

        // Latency from the instruction class, independent of the state walk below.
        case (op)
            6'h23:                      base = 5;
            6'h2B, 6'h00, 6'h08:        base = 4;
            6'h04, 6'h02, 6'h03:        base = 3;
            default:                    base = 2;
        endcase
        lat = base + fw + (is_mem ? mw : 0);

        // Expected state walk.
        repeat (fw + 1) exp_q.push_back(4'd0);
        exp_q.push_back(4'd1);
        case (op)
            6'h23: begin exp_q.push_back(4'd2); repeat (mw + 1) exp_q.push_back(4'd3); exp_q.push_back(4'd4); end
            6'h2B: begin exp_q.push_back(4'd2); repeat (mw + 1) exp_q.push_back(4'd5); end
            6'h00: begin exp_q.push_back(4'd6); exp_q.push_back(4'd7); end
            6'h04: exp_q.push_back(4'd8);
            6'h08: begin exp_q.push_back(4'd10); exp_q.push_back(4'd11); end
            6'h02: exp_q.push_back(4'd9);
            6'h03: exp_q.push_back(4'd12);
            default: ;
        endcase

        exp_rw  = (is_lw || op == 6'h00 || op == 6'h08 || op == 6'h03) ? 1 : 0;
        exp_pcw = 1 + ((op == 6'h04 && z) ? 1 : 0) + ((op == 6'h02 || op == 6'h03) ? 1 : 0);
        case (op)
            6'h23:   begin exp_dst = 2'd0; exp_m2r = 2'd1; end
            6'h00:   begin exp_dst = 2'd1; exp_m2r = 2'd0; end
            6'h03:   begin exp_dst = 2'd2; exp_m2r = 2'd2; end
            default: begin exp_dst = 2'd0; exp_m2r = 2'd0; end
        endcase

        n_rw = 0; n_mw = 0; n_pcw = 0; n_irw = 0; n_done = 0; n_ill = 0;
        for (int c = 0; c < lat; c++) begin
            @(negedge clk);
            opcode = op;
            zero   = (c == fw + 2) ? z : 1'($urandom_range(0, 1));
            if (c < fw)                                             mem_ready = 1'b0;
            else if (c == fw)                                       mem_ready = 1'b1;
            else if (is_mem && c >= fw + 3 && c < fw + 3 + mw)      mem_ready = 1'b0;
            else if (is_mem && c == fw + 3 + mw)                    mem_ready = 1'b1;
            else                                                    mem_ready = 1'($urandom_range(0, 1));
            #1;
            exp_s = (exp_q.size() > 0) ? exp_q.pop_front() : 4'd0;
            checks++;
            if (state !== exp_s) begin
                errors++;
                $display("FAIL state op=%h cyc%0d: got %0d want %0d", op, c, state, exp_s);
            end
            if (reg_write === 1'b1) begin
                n_rw++;
                checks++;
                if (reg_dst !== exp_dst || mem_to_reg !== exp_m2r || c != lat - 1) begin
                    errors++;
                    $display("FAIL wb_sel op=%h cyc%0d: got dst=%0d m2r=%0d want dst=%0d m2r=%0d at cyc%0d",
                             op, c, reg_dst, mem_to_reg, exp_dst, exp_m2r, lat - 1);
                end
            end
            if (mem_write === 1'b1) begin
                n_mw++;
                checks++;
                if (i_or_d !== 1'b1) begin
                    errors++;
                    $display("FAIL sw_addr op=%h cyc%0d: got i_or_d=%0d want 1", op, c, i_or_d);
                end
            end
            if (pc_write === 1'b1)  n_pcw++;
            if (ir_write === 1'b1)  n_irw++;
            if (illegal_op === 1'b1) begin
                n_ill++;
                checks++;
                if (c != fw + 1) begin
                    errors++;
                    $display("FAIL ill_cycle op=%h: got cyc%0d want cyc%0d", op, c, fw + 1);
                end
            end
            if (instr_done === 1'b1) begin
                n_done++;
                checks++;
                if (c != lat - 1) begin
                    errors++;
                    $display("FAIL done_cycle op=%h: got cyc%0d want cyc%0d", op, c, lat - 1);
                end
            end
            if (op == 6'h04 && c == fw + 2) begin
                checks++;
                if (pc_src !== 2'd1 || alu_op !== 2'd1 || pc_write !== z) begin
                    errors++;
                    $display("FAIL beq_sel z=%0d: got pc_src=%0d alu_op=%0d pcw=%0d want 1 1 %0d",
                             z, pc_src, alu_op, pc_write, z);
                end
            end
            if (op == 6'h03 && c == fw + 2) begin
                checks++;
                if (pc_src !== 2'd2) begin
                    errors++;
                    $display("FAIL jal_pcsrc: got %0d want 2", pc_src);
                end
            end
        end

        checks++;
        if (n_rw != exp_rw || n_mw != (is_sw ? mw + 1 : 0) || n_pcw != exp_pcw || n_irw != 1 ||
            n_done != (legal ? 1 : 0) || n_ill != (legal ? 0 : 1)) begin
            errors++;
            $display("FAIL counts op=%h fw=%0d mw=%0d: got rw=%0d mw=%0d pcw=%0d irw=%0d done=%0d ill=%0d want rw=%0d mw=%0d pcw=%0d irw=1 done=%0d ill=%0d",
                     op, fw, mw, n_rw, n_mw, n_pcw, n_irw, n_done, n_ill,
                     exp_rw, is_sw ? mw + 1 : 0, exp_pcw, legal ? 1 : 0, legal ? 0 : 1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'h00; zero = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (all_out !== '0) begin errors++; $display("FAIL reset_outs: got %h want 0", all_out); end
        @(negedge clk); rst_n = 1'b1; #1;
        checks++;
        if (state !== 4'd0 || ir_write !== 1'b1 || pc_write !== 1'b1) begin
            errors++; $display("FAIL reset_release: got st=%0d irw=%0d pcw=%0d want 0 1 1", state, ir_write, pc_write);
        end
        @(negedge clk); #1;
        checks++;
        if (state !== 4'd1) begin errors++; $display("FAIL pre_decode: got %0d want 1", state); end
        rst_n = 1'b0; #1;
        checks++;
        if (all_out !== '0) begin errors++; $display("FAIL reset_in_decode: got %h want 0", all_out); end
        @(negedge clk); rst_n = 1'b1; #1;
        checks++;
        if (state !== 4'd0 || ir_write !== 1'b1 || pc_write !== 1'b1) begin
            errors++; $display("FAIL rerelease: got st=%0d irw=%0d pcw=%0d want 0 1 1", state, ir_write, pc_write);
        end
        // Let the R-type in flight finish: 0 -> 1 -> 6 -> 7 -> 0.
        repeat (4) @(posedge clk);
    endtask

    task automatic test_lw();
        run_instr(6'h23, 1'b0, 0, 0);
        run_instr(6'h23, 1'b1, 1, 2);
    endtask

    task automatic test_sw();
        run_instr(6'h2B, 1'b0, 0, 2);
        run_instr(6'h2B, 1'b1, 0, 0);
    endtask

    task automatic test_beq();
        run_instr(6'h04, 1'b1, 0, 0);
        run_instr(6'h04, 1'b0, 0, 0);
    endtask

    task automatic test_other_ops();
        run_instr(6'h03, 1'b0, 0, 0);
        run_instr(6'h00, 1'b0, 2, 0);
        run_instr(6'h08, 1'b1, 0, 0);
        run_instr(6'h02, 1'b0, 1, 0);
    endtask

    task automatic test_illegal();
        run_instr(6'h3F, 1'b0, 0, 0);
        run_instr(6'h05, 1'b1, 1, 0);
    endtask

    task automatic test_jal_disabled();
        int tries;
        d2_opcode = 6'h03; d2_zero = 1'b0; d2_mem_ready = 1'b0;
        tries = 0;
        do begin
            @(negedge clk); #1;
            tries++;
        end while (d2_state !== 4'd0 && tries < 8);
        checks++;
        if (d2_state !== 4'd0 || d2_ir_write !== 1'b1) begin
            errors++; $display("FAIL d2_fetch: got st=%0d irw=%0d want 0 1", d2_state, d2_ir_write);
        end
        @(negedge clk); #1;
        checks++;
        if (d2_state !== 4'd1 || d2_illegal_op !== 1'b1 || d2_instr_done !== 1'b0) begin
            errors++; $display("FAIL d2_decode: got st=%0d ill=%0d done=%0d want 1 1 0",
                               d2_state, d2_illegal_op, d2_instr_done);
        end
        @(negedge clk); #1;
        checks++;
        if (d2_state !== 4'd0 || d2_illegal_op !== 1'b0) begin
            errors++; $display("FAIL d2_back: got st=%0d ill=%0d want 0 0", d2_state, d2_illegal_op);
        end
    endtask

    task automatic test_recovery();
        @(posedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        force dut.state_q = 4'd14;
        #1;
        checks++;
        if (state !== 4'd14 || all_out[21:4] !== '0) begin
            errors++; $display("FAIL unused_state: got st=%0d outs=%h want 14 0", state, all_out[21:4]);
        end
        #1;
        release dut.state_q;
        @(negedge clk); #1;
        checks++;
        if (state !== 4'd0) begin errors++; $display("FAIL recovery: got %0d want 0", state); end
    endtask

    task automatic test_random();
        logic [5:0] legal_ops[7];
        logic [5:0] op;
        legal_ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h08, 6'h23, 6'h2B};
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                op = 6'($urandom_range(0, 63));
                while (is_legal(op)) op = 6'($urandom_range(0, 63));
            end else begin
                op = legal_ops[$urandom_range(0, 6)];
            end
            run_instr(op, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3));
        end
    endtask

    initial begin
        rst_n = 1'b0; opcode = 6'h00; zero = 1'b0; mem_ready = 1'b1;
        d2_opcode = 6'h3F; d2_zero = 1'b0; d2_mem_ready = 1'b0;
        test_reset();
        test_lw();
        test_sw();
        test_beq();
        test_other_ops();
        test_illegal();
        test_jal_disabled();
        test_recovery();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
